// File: rtl/psr_pkg.sv
// Shared types for the parametrised shift register.
//   psr_mode_e  : 3-bit operation code sampled with start.
//   psr_state_e : sequencing state (idle or stepping through a shift).
package psr_pkg;

   typedef enum logic [2:0] {
      PSR_HOLD = 3'b000,
      PSR_LOAD = 3'b001,
      PSR_SHL  = 3'b010,
      PSR_SHR  = 3'b011,
      PSR_ROL  = 3'b100,
      PSR_ROR  = 3'b101,
      PSR_ASR  = 3'b110,
      PSR_CLR  = 3'b111
   } psr_mode_e;

   typedef enum logic {
      PSR_IDLE  = 1'b0,
      PSR_SHIFT = 1'b1
   } psr_state_e;

endpackage

// File: rtl/psr_if.sv
// Request/status bundle of param_shift_register.
//   start, mode, amount, in, ser_in : requester -> register
//   out, busy, done                 : register  -> requester
//   parity (only with PSR_PARITY_EN): XOR reduction of out, registered
// master modport is the requester side, slave modport the register side.
interface psr_if #(
   parameter int WIDTH = 8
);
   localparam int AMT_W = $clog2(WIDTH) + 1;

   logic             start;
   logic [2:0]       mode;
   logic [AMT_W-1:0] amount;
   logic [WIDTH-1:0] in;
   logic             ser_in;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
`ifdef PSR_PARITY_EN
   logic             parity;

   modport master (output start, mode, amount, in, ser_in,
                   input  out, busy, done, parity);
   modport slave  (input  start, mode, amount, in, ser_in,
                   output out, busy, done, parity);
`else
   modport master (output start, mode, amount, in, ser_in,
                   input  out, busy, done);
   modport slave  (input  start, mode, amount, in, ser_in,
                   output out, busy, done);
`endif

endinterface

// File: rtl/psr_step_unit.sv
// Combinational single-bit step of a shift/rotate.
//   value   : current register contents
//   mode    : latched operation (only shift/rotate codes change the value)
//   ser_in  : fill bit for SHL (enters bit 0) and SHR (enters MSB)
//   next    : value after one step
module psr_step_unit
   import psr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  psr_mode_e        mode,
   input  logic             ser_in,
   output logic [WIDTH-1:0] next
);

   always_comb begin
      next = value;
      case (mode)
         PSR_SHL: next = {value[WIDTH-2:0], ser_in};
         PSR_SHR: next = {ser_in, value[WIDTH-1:1]};
         PSR_ROL: next = {value[WIDTH-2:0], value[WIDTH-1]};
         PSR_ROR: next = {value[0], value[WIDTH-1:1]};
         PSR_ASR: next = {value[WIDTH-1], value[WIDTH-1:1]};
         default: next = value;
      endcase
   end

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit register with parallel load, clear and multi-cycle shift/rotate
// (one bit per cycle) under a start/busy/done handshake.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts a running shift, no done)
//   bus  : psr_if slave side (start/mode/amount/in/ser_in in,
//          out/busy/done out, plus parity when PSR_PARITY_EN is defined)
// Optional feature macro: PSR_PARITY_EN adds a registered parity output.
module param_shift_register
   import psr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic  clk,
   input logic  rst,
   psr_if.slave bus
);

   localparam int AMT_W = $clog2(WIDTH) + 1;
   localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);

   psr_state_e       state_q, state_d;
   psr_mode_e        mode_q, mode_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] step_val;
   psr_mode_e        start_mode;

   assign start_mode = psr_mode_e'(bus.mode);

   psr_step_unit #(.WIDTH(WIDTH)) u_step (
      .value  (out_q),
      .mode   (mode_q),
      .ser_in (bus.ser_in),
      .next   (step_val)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         PSR_IDLE: begin
            if (bus.start) begin
               case (start_mode)
                  PSR_HOLD: done_d = 1'b1;
                  PSR_LOAD: begin
                     out_d  = bus.in;
                     done_d = 1'b1;
                  end
                  PSR_CLR: begin
                     out_d  = '0;
                     done_d = 1'b1;
                  end
                  default: begin
                     if (bus.amount == '0) begin
                        done_d = 1'b1;
                     end else begin
                        // Shifting more than WIDTH steps is pointless, and a
                        // rotate by WIDTH must land back on the start value.
                        mode_d  = start_mode;
                        cnt_d   = (bus.amount > WIDTH_A) ? WIDTH_A : bus.amount;
                        state_d = PSR_SHIFT;
                     end
                  end
               endcase
            end
         end
         PSR_SHIFT: begin
            out_d = step_val;
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = PSR_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = PSR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PSR_IDLE;
         mode_q  <= PSR_HOLD;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = (state_q == PSR_SHIFT);
   assign bus.done = done_q;

`ifdef PSR_PARITY_EN
   logic parity_q, parity_d;

   assign parity_d = ^out_d;

   always_ff @(posedge clk) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= parity_d;
   end

   assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_param_shift_register.sv
// Directed bench for param_shift_register (WIDTH=8). Expected per-cycle
// out/busy/done values are queued as each operation is issued and popped
// one per clock edge when the DUT outputs are sampled.
module tb_param_shift_register;
   import psr_pkg::*;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [7:0] o;
      logic       b;
      logic       d;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   assertions;
   int   failures;

   psr_if #(.WIDTH(WIDTH)) bus ();

   param_shift_register #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [7:0] o, input logic b, input logic d);
      exp_t e;
      e.o = o;
      e.b = b;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Advance n edges; after each one compare the DUT against the next entry.
   task automatic check(input int n, input string tag);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            assertions++;
            failures++;
            $error("FAIL %s: scoreboard empty at cycle %0d", tag, i);
         end else begin
            e = exp_q.pop_front();
            assertions++;
            assert (bus.out === e.o) else begin
               failures++;
               $error("FAIL %s[%0d] out: got %h expected %h", tag, i, bus.out, e.o);
            end
            assertions++;
            assert (bus.busy === e.b) else begin
               failures++;
               $error("FAIL %s[%0d] busy: got %b expected %b", tag, i, bus.busy, e.b);
            end
            assertions++;
            assert (bus.done === e.d) else begin
               failures++;
               $error("FAIL %s[%0d] done: got %b expected %b", tag, i, bus.done, e.d);
            end
`ifdef PSR_PARITY_EN
            assertions++;
            assert (bus.parity === ^e.o) else begin
               failures++;
               $error("FAIL %s[%0d] parity: got %b expected %b", tag, i, bus.parity, ^e.o);
            end
`endif
         end
      end
   endtask

   task automatic go(input logic [2:0] m, input logic [3:0] amt,
                     input logic [7:0] din, input logic sin);
      bus.start  = 1'b1;
      bus.mode   = m;
      bus.amount = amt;
      bus.in     = din;
      bus.ser_in = sin;
   endtask

   // Issue a single-edge operation (HOLD/LOAD/CLR or zero-amount shift).
   task automatic quick(input logic [2:0] m, input logic [3:0] amt,
                        input logic [7:0] din, input logic [7:0] res, input string tag);
      go(m, amt, din, 1'b0);
      push(res, 1'b0, 1'b1);
      check(1, tag);
      bus.start = 1'b0;
      push(res, 1'b0, 1'b0);
      check(1, tag);
   endtask

   initial begin
      logic [7:0] v;
      assertions = 0;
      failures   = 0;

      // Reset from an arbitrary starting point with a random request pending.
      rst        = 1'b1;
      bus.start  = 1'b1;
      bus.mode   = 3'($urandom);
      bus.amount = 4'($urandom);
      bus.in     = 8'($urandom);
      bus.ser_in = 1'($urandom);
      push(8'h00, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b0);
      check(2, "reset");
      rst       = 1'b0;
      bus.start = 1'b0;
      push(8'h00, 1'b0, 1'b0);
      check(1, "idle");

      quick(3'b001, 4'd0, 8'hA5, 8'hA5, "load");

      // SHL by 3 with ser_in=1 held.
      go(3'b010, 4'd3, 8'h00, 1'b1);
      push(8'hA5, 1'b1, 1'b0);
      push(8'h4B, 1'b1, 1'b0);
      push(8'h97, 1'b1, 1'b0);
      push(8'h2F, 1'b0, 1'b1);
      push(8'h2F, 1'b0, 1'b0);
      check(1, "shl");
      bus.start = 1'b0;
      check(4, "shl");

      quick(3'b001, 4'd0, 8'h3C, 8'h3C, "load3c");
      go(3'b101, 4'd1, 8'h00, 1'b0);
      push(8'h3C, 1'b1, 1'b0);
      push(8'h1E, 1'b0, 1'b1);
      check(1, "ror1");
      bus.start = 1'b0;
      check(1, "ror1");

      // ROR by WIDTH: eight busy cycles, back to the start value.
      quick(3'b001, 4'd0, 8'h3C, 8'h3C, "load3c");
      go(3'b101, 4'd8, 8'h00, 1'b0);
      v = 8'h3C;
      push(v, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) begin
         v = {v[0], v[7:1]};
         push(v, 1'b1, 1'b0);
      end
      push(8'h3C, 1'b0, 1'b1);
      check(1, "ror8");
      bus.start = 1'b0;
      check(8, "ror8");

      // ROL by 15 is clamped to 8 steps.
      go(3'b100, 4'd15, 8'h00, 1'b0);
      v = 8'h3C;
      push(v, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) begin
         v = {v[6:0], v[7]};
         push(v, 1'b1, 1'b0);
      end
      push(8'h3C, 1'b0, 1'b1);
      push(8'h3C, 1'b0, 1'b0);
      check(1, "rol15");
      bus.start = 1'b0;
      check(9, "rol15");

      // ASR replicates the MSB and ignores ser_in.
      quick(3'b001, 4'd0, 8'h90, 8'h90, "load90");
      go(3'b110, 4'd2, 8'h00, 1'b0);
      push(8'h90, 1'b1, 1'b0);
      push(8'hC8, 1'b1, 1'b0);
      push(8'hE4, 1'b0, 1'b1);
      check(1, "asr");
      bus.start = 1'b0;
      check(2, "asr");

      quick(3'b001, 4'd0, 8'h90, 8'h90, "load90");
      quick(3'b011, 4'd0, 8'h00, 8'h90, "shr0");

      // CLR requested while busy is ignored; LOAD in the done cycle is taken.
      go(3'b010, 4'd4, 8'h00, 1'b0);
      push(8'h90, 1'b1, 1'b0);
      push(8'h20, 1'b1, 1'b0);
      push(8'h40, 1'b1, 1'b0);
      push(8'h80, 1'b1, 1'b0);
      push(8'h00, 1'b0, 1'b1);
      check(1, "busy_start");
      bus.start = 1'b0;
      check(1, "busy_start");
      go(3'b111, 4'd1, 8'hFF, 1'b0);
      check(3, "busy_start");
      go(3'b001, 4'd0, 8'h5A, 1'b0);
      push(8'h5A, 1'b0, 1'b1);
      check(1, "b2b");
      bus.start = 1'b0;
      push(8'h5A, 1'b0, 1'b0);
      check(1, "b2b");

      quick(3'b111, 4'd0, 8'h00, 8'h00, "clr");
      quick(3'b001, 4'd0, 8'hC3, 8'hC3, "loadc3");
      quick(3'b000, 4'd0, 8'h11, 8'hC3, "hold");

      // Reset with three steps remaining: no done pulse afterwards.
      quick(3'b001, 4'd0, 8'hFF, 8'hFF, "loadff");
      go(3'b011, 4'd5, 8'h00, 1'b0);
      push(8'hFF, 1'b1, 1'b0);
      push(8'h7F, 1'b1, 1'b0);
      push(8'h3F, 1'b1, 1'b0);
      check(1, "abort");
      bus.start = 1'b0;
      check(2, "abort");
      rst = 1'b1;
      push(8'h00, 1'b0, 1'b0);
      check(1, "abort_rst");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h00, 1'b0, 1'b0);
      check(4, "abort_after");

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Parametrised successor to the fixed 8-bit parallel register.
- A WIDTH-bit register that supports parallel load, clear, and multi-cycle shift/rotate by a programmable amount, with a start/busy/done handshake.
- Sits in the datapath library beside the plain registers.
- Used by the ALU and serial-conversion blocks where a shift takes one bit per cycle.

Parameters:
- WIDTH, 8, data width in bits; must be >= 2.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount port (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only while idle.
- mode  input  3  operation code, sampled with start.
- amount  input  AMT_W  shift count, sampled with start.
- in  input  WIDTH  parallel load data, sampled with start.
- ser_in  input  1  serial fill bit for SHL/SHR; sampled on every shift edge.
- out  output  WIDTH  register contents.
- busy  output  1  high while a shift sequence is in progress.
- done  output  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset: rst is synchronous and active-high. On a reset edge: out=0, busy=0, done=0, state=IDLE, internal count=0. Reset overrides everything, including a sequence mid-shift, which is aborted with no done pulse.
- Mode codes:
  - 000 HOLD
  - 001 LOAD
  - 010 SHL: shift left, ser_in enters bit0.
  - 011 SHR: shift right, ser_in enters MSB.
  - 100 ROL
  - 101 ROR
  - 110 ASR: arithmetic shift right, MSB replicated, ser_in ignored.
  - 111 CLR
- States: IDLE, SHIFT.
- IDLE with start=1 at edge T:
  - HOLD, LOAD, CLR: out updated at edge T (unchanged, in, or 0 respectively). done=1 in the cycle after edge T. State stays IDLE and busy stays 0.
  - Shift modes with amount=0: no change to out; done=1 after edge T; state stays IDLE.
  - Shift modes with amount=N>=1: latch mode, set count=min(N,WIDTH), go to SHIFT, busy=1. out is unchanged at edge T.
- SHIFT: each edge applies one single-bit step of the latched mode and decrements count.
  - On the edge where count==1: apply the final step, go to IDLE, busy=0, done=1.
  - Totals: out is final after edge T+N; busy is high for N cycles; done is high for exactly one cycle after edge T+N.
- amount > WIDTH is clamped to WIDTH. A rotate by WIDTH returns the original value.
- start while busy is ignored: mode, amount and in are not sampled and the sequence is unaffected.
- start during the done cycle (back to back) is accepted, because the block is already IDLE.
- done is never high together with busy.

Optional Feature:
- Macro: PSR_PARITY_EN.
- Defined: adds output port parity (1 bit), equal to the XOR reduction of out. It is registered and updates on the same edge as out; reset value 0.
- Undefined: the parity port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package psr_pkg holds:
  - mode enum (PSR_HOLD..PSR_CLR, 3-bit)
  - state enum (PSR_IDLE, PSR_SHIFT)
- One combinational sub-module, psr_step_unit: given value, latched mode and ser_in, returns the one-step next value. The FSM, counter and handshake stay in the top module.

Test Plan (WIDTH=8):
- Reset: hold rst high for 2 edges from random state -> out=0x00, busy=0, done=0. Assert rst during a SHIFT with 3 steps left -> out=0x00 next cycle, no done pulse.
- LOAD: start, mode=001, in=0xA5 -> out=0xA5 after 1 edge, done pulse of 1 cycle, busy never high.
- SHL with fill: from 0xA5, start mode=010, amount=3, ser_in=1 held -> out goes 0x4B, 0x97, 0x2F on successive edges. busy high for 3 cycles, then a done pulse.
- Rotate: from 0x3C, ROR amount=1 -> 0x1E. ROR amount=8 -> 0x3C with busy for 8 cycles. ROL amount=15 is clamped to 8 -> 0x3C.
- ASR and zero amount: from 0x90, ASR amount=2 -> 0xE4. SHR amount=0 -> out stays 0x90, done after 1 edge, busy=0.
- Ignored start: during SHL amount=4, pulse start with mode=111 -> no clear, the shift completes normally. A start in the done cycle is accepted immediately.
